// File: rtl/xge_axi_pkg.sv
// Shared widths, state encoding and tuser packing for the XGE MAC <-> AXI64 bridges.
package xge_axi_pkg;
    localparam int XGE_DATA_W    = 64;
    localparam int XGE_MOD_W     = 3;
    localparam int AXI_TUSER_W   = 4;
    localparam int TUSER_ERR_BIT = 3;
    // One buffer entry: {tlast, tuser, tdata}
    localparam int BUF_W         = 1 + AXI_TUSER_W + XGE_DATA_W;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } rx_state_t;

    function automatic logic [AXI_TUSER_W-1:0] eop_tuser(
        input logic                 eop,
        input logic                 err,
        input logic [XGE_MOD_W-1:0] mod
    );
        logic [AXI_TUSER_W-1:0] t;
        t = '0;
        if (eop) begin
            t[XGE_MOD_W-1:0] = mod;
            t[TUSER_ERR_BIT] = err;
        end
        return t;
    endfunction
endpackage

// File: rtl/axi64_rx_buffer.sv
// Small show-ahead FIFO holding {tlast, tuser, tdata}; exposes registered occupancy
// so the parent can issue MAC reads only when an in-flight word is guaranteed room.
module axi64_rx_buffer
    import xge_axi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BUF_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/xge64_to_axi64_rx.sv
// XGE MAC RX FIFO to 64-bit AXI-Stream master: credit-gated MAC reads, framing FSM
// that drops orphan words, and frame/error counters.
module xge64_to_axi64_rx
    import xge_axi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                   xgmii_clk,
    input  logic                   xgmii_reset,
    input  logic                   pkt_rx_avail,
    output logic                   pkt_rx_ren,
    input  logic [XGE_DATA_W-1:0]  pkt_rx_data,
    input  logic                   pkt_rx_val,
    input  logic                   pkt_rx_sop,
    input  logic                   pkt_rx_eop,
    input  logic [XGE_MOD_W-1:0]   pkt_rx_mod,
    input  logic                   pkt_rx_err,
    output logic [XGE_DATA_W-1:0]  rx_axis_tdata,
    output logic [AXI_TUSER_W-1:0] rx_axis_tuser,
    output logic                   rx_axis_tlast,
    output logic                   rx_axis_tvalid,
    input  logic                   rx_axis_tready,
    output logic [CNT_W-1:0]       rx_pkt_cnt,
    output logic [CNT_W-1:0]       rx_err_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic              r_ren_q;
    logic              r_orphan;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [CW-1:0]     w_count;
    logic              w_room;
    logic              w_write;
    logic              w_eop_wr;
    logic              w_orphan;
    logic              w_sop_in_pkt;
    logic              w_tvalid;
    logic              w_pop;
    logic [BUF_W-1:0]  w_din;
    logic [BUF_W-1:0]  w_dout;

    // A word requested last cycle still needs a slot, hence ren_q in the credit sum.
    assign w_room     = (w_count + CW'(r_ren_q)) < CW'(DEPTH);
    assign pkt_rx_ren = !xgmii_reset && w_room && ((r_state == IN_PKT) || pkt_rx_avail);

    assign w_write      = pkt_rx_val && ((r_state == IN_PKT) || pkt_rx_sop);
    assign w_eop_wr     = w_write && pkt_rx_eop;
    assign w_orphan     = pkt_rx_val && (r_state == IDLE) && !pkt_rx_sop;
    assign w_sop_in_pkt = pkt_rx_val && (r_state == IN_PKT) && pkt_rx_sop;

    assign w_din = {pkt_rx_eop, eop_tuser(pkt_rx_eop, pkt_rx_err, pkt_rx_mod), pkt_rx_data};

    assign w_tvalid = (w_count != '0);
    assign w_pop    = w_tvalid && rx_axis_tready;

    axi64_rx_buffer #(
        .DEPTH (DEPTH),
        .W     (BUF_W)
    ) u_buf (
        .i_clk   (xgmii_clk),
        .i_rst   (xgmii_reset),
        .i_push  (w_write),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_count (w_count)
    );

    // Outputs read as zero when empty so stale entries never leak onto the bus.
    assign rx_axis_tvalid = w_tvalid;
    assign rx_axis_tdata  = w_tvalid ? w_dout[XGE_DATA_W-1:0] : '0;
    assign rx_axis_tuser  = w_tvalid ? w_dout[XGE_DATA_W +: AXI_TUSER_W] : '0;
    assign rx_axis_tlast  = w_tvalid ? w_dout[BUF_W-1] : 1'b0;
    assign rx_pkt_cnt     = r_pkt_cnt;
    assign rx_err_cnt     = r_err_cnt;

    always_comb begin
        w_state_nxt = r_state;
        if (pkt_rx_val) begin
            case (r_state)
                IDLE:    if (pkt_rx_sop && !pkt_rx_eop) w_state_nxt = IN_PKT;
                IN_PKT:  if (pkt_rx_eop) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge xgmii_clk or posedge xgmii_reset) begin
        if (xgmii_reset) begin
            r_state <= IDLE;
            r_ren_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ren_q <= pkt_rx_ren;
        end
    end

    // r_orphan marks an orphan run in progress so only its first word is counted.
    always_ff @(posedge xgmii_clk or posedge xgmii_reset) begin
        if (xgmii_reset) begin
            r_orphan  <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_orphan) begin
                r_orphan <= 1'b1;
            end else if (w_eop_wr) begin
                r_orphan <= 1'b0;
            end
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(w_eop_wr);
            r_err_cnt <= r_err_cnt + CNT_W'(w_orphan && !r_orphan)
                                   + CNT_W'(w_sop_in_pkt)
                                   + CNT_W'(w_eop_wr && pkt_rx_err);
        end
    end
endmodule
